ex_operand_stage: RTL and testbench

- ID/EX pipeline register that sits directly upstream of the ALU in the dynamic pipeline.
- Captures decoded instructions from ID and resolves operands with EX/MEM forwarding.
- Inserts load-use bubbles and drives registered src1/src2/aluc into the ALU under a valid/ready handshake with flush support.

---
 rtl/ex_operand_stage.sv | 168 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register that sits directly in front of the ALU.
//   - Resolves rs/rt operands at capture time. Priority is EX forward, then
//     MEM forward, then the register file. Index 0 always reads as zero.
//   - Stalls ID for one cycle when a load in EX produces a source that this
//     instruction uses (load-use bubble).
//   - Presents registered src1/src2/aluc and sideband fields to EX under a
//     valid/ready handshake. flush drops whatever the stage holds.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   flush                  discard the held instruction and block capture
//   id_*                   decoded instruction from ID (id_valid/id_ready)
//   ex_fwd_*, mem_fwd_*    forwarding taps from the EX and MEM producers
//   ex_valid/ex_ready      handshake toward the ALU
//   src1, src2, aluc       ALU operands and opcode
//   ex_pc, ex_rd_idx, ex_wen, ex_is_load, ex_rt_fwd   sideband / store data
module ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [REGW-1:0] id_rs_idx,
    input  logic [REGW-1:0] id_rt_idx,
    input  logic [XLEN-1:0] id_rs_val,
    input  logic [XLEN-1:0] id_rt_val,
    input  logic [15:0]     id_imm16,
    input  logic [4:0]      id_shamt,
    input  logic [1:0]      id_src1_sel,
    input  logic [1:0]      id_src2_sel,
    input  logic [3:0]      id_aluc,
    input  logic [REGW-1:0] id_rd_idx,
    input  logic            id_wen,
    input  logic            id_is_load,
    input  logic            ex_fwd_wen,
    input  logic            ex_fwd_is_load,
    input  logic [REGW-1:0] ex_fwd_idx,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            mem_fwd_wen,
    input  logic [REGW-1:0] mem_fwd_idx,
    input  logic [XLEN-1:0] mem_fwd_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] src1,
    output logic [XLEN-1:0] src2,
    output logic [3:0]      aluc,
    output logic [XLEN-1:0] ex_pc,
    output logic [REGW-1:0] ex_rd_idx,
    output logic            ex_wen,
    output logic            ex_is_load,
    output logic [XLEN-1:0] ex_rt_fwd
);

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] src1_q, src1_d;
    logic [XLEN-1:0] src2_q, src2_d;
    logic [3:0]      aluc_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [REGW-1:0] ex_rd_idx_q;
    logic            ex_wen_q, ex_is_load_q;
    logic [XLEN-1:0] ex_rt_fwd_q;

    logic [XLEN-1:0] fwd_rs, fwd_rt;
    logic [XLEN-1:0] imm_zx, imm_sx, imm_hi;
    logic            uses_rs, uses_rt, load_use, capture;

    // Operand forwarding; a zero index short-circuits every source.
    always_comb begin
        fwd_rs = id_rs_val;
        if (id_rs_idx == '0)
            fwd_rs = '0;
        else if (ex_fwd_wen && ex_fwd_idx == id_rs_idx)
            fwd_rs = ex_fwd_data;
        else if (mem_fwd_wen && mem_fwd_idx == id_rs_idx)
            fwd_rs = mem_fwd_data;

        fwd_rt = id_rt_val;
        if (id_rt_idx == '0)
            fwd_rt = '0;
        else if (ex_fwd_wen && ex_fwd_idx == id_rt_idx)
            fwd_rt = ex_fwd_data;
        else if (mem_fwd_wen && mem_fwd_idx == id_rt_idx)
            fwd_rt = mem_fwd_data;
    end

    // rt is a real source either as ALU operand or as store data (no rd write).
    assign uses_rs  = (id_src1_sel == 2'b00) || (id_src1_sel == 2'b10);
    assign uses_rt  = (id_src2_sel == 2'b00) || !id_wen;
    assign load_use = ex_fwd_wen && ex_fwd_is_load && (ex_fwd_idx != '0) &&
                      ((uses_rs && ex_fwd_idx == id_rs_idx) ||
                       (uses_rt && ex_fwd_idx == id_rt_idx));

    assign id_ready = (!ex_valid_q || ex_ready) && !load_use && !flush && !rst;
    assign capture  = id_valid && id_ready;

    assign imm_zx = XLEN'(id_imm16);
    assign imm_sx = XLEN'($signed(id_imm16));
    assign imm_hi = imm_zx << 16;

    always_comb begin
        src1_d = '0;
        unique case (id_src1_sel)
            2'b00:   src1_d = fwd_rs;
            2'b01:   src1_d = XLEN'(id_shamt);
            2'b10:   src1_d = XLEN'(fwd_rs[4:0]);
            default: src1_d = '0;
        endcase

        src2_d = '0;
        unique case (id_src2_sel)
            2'b00:   src2_d = fwd_rt;
            2'b01:   src2_d = imm_sx;
            2'b10:   src2_d = imm_zx;
            default: src2_d = imm_hi;
        endcase

        // A held instruction survives only while EX is stalling it and no
        // flush arrives; capture already excludes flush via id_ready.
        ex_valid_d = 1'b0;
        if (capture)
            ex_valid_d = 1'b1;
        else if (!flush && ex_valid_q && !ex_ready)
            ex_valid_d = 1'b1;
    end

    // Data registers load only on capture, so a held instruction keeps the
    // operands resolved when it entered the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            aluc_q       <= '0;
            ex_pc_q      <= '0;
            ex_rd_idx_q  <= '0;
            ex_wen_q     <= 1'b0;
            ex_is_load_q <= 1'b0;
            ex_rt_fwd_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            if (capture) begin
                src1_q       <= src1_d;
                src2_q       <= src2_d;
                aluc_q       <= id_aluc;
                ex_pc_q      <= id_pc;
                ex_rd_idx_q  <= id_rd_idx;
                ex_wen_q     <= id_wen;
                ex_is_load_q <= id_is_load;
                ex_rt_fwd_q  <= fwd_rt;
            end
        end
    end

    assign ex_valid   = ex_valid_q;
    assign src1       = src1_q;
    assign src2       = src2_q;
    assign aluc       = aluc_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rd_idx  = ex_rd_idx_q;
    assign ex_wen     = ex_wen_q;
    assign ex_is_load = ex_is_load_q;
    assign ex_rt_fwd  = ex_rt_fwd_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready;
    logic [31:0] id_pc, id_rs_val, id_rt_val;
    logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx, id_shamt;
    logic [15:0] id_imm16;
    logic [1:0]  id_src1_sel, id_src2_sel;
    logic [3:0]  id_aluc;
    logic        id_wen, id_is_load;
    logic        ex_fwd_wen, ex_fwd_is_load, mem_fwd_wen;
    logic [4:0]  ex_fwd_idx, mem_fwd_idx;
    logic [31:0] ex_fwd_data, mem_fwd_data;
    logic        ex_valid, ex_ready;
    logic [31:0] src1, src2, ex_pc, ex_rt_fwd;
    logic [3:0]  aluc;
    logic [4:0]  ex_rd_idx;
    logic        ex_wen, ex_is_load;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_imm16(id_imm16), .id_shamt(id_shamt),
        .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
        .id_aluc(id_aluc), .id_rd_idx(id_rd_idx), .id_wen(id_wen),
        .id_is_load(id_is_load),
        .ex_fwd_wen(ex_fwd_wen), .ex_fwd_is_load(ex_fwd_is_load),
        .ex_fwd_idx(ex_fwd_idx), .ex_fwd_data(ex_fwd_data),
        .mem_fwd_wen(mem_fwd_wen), .mem_fwd_idx(mem_fwd_idx),
        .mem_fwd_data(mem_fwd_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .src1(src1), .src2(src2), .aluc(aluc), .ex_pc(ex_pc),
        .ex_rd_idx(ex_rd_idx), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_rt_fwd(ex_rt_fwd)
    );

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv;
        logic [15:0] imm;
        logic [4:0]  sh;
        logic [1:0]  s1, s2;
        logic [3:0]  op;
        logic        wen, ld;
        logic        exw, exl;
        logic [4:0]  exi;
        logic [31:0] exd;
        logic        mw;
        logic [4:0]  mi;
        logic [31:0] md;
        logic [31:0] e1, e2, ert;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input logic [31:0] pc);
        id_rs_idx = v.rs;  id_rt_idx = v.rt;  id_rd_idx = v.rd;
        id_rs_val = v.rsv; id_rt_val = v.rtv; id_imm16 = v.imm;
        id_shamt = v.sh;   id_src1_sel = v.s1; id_src2_sel = v.s2;
        id_aluc = v.op;    id_wen = v.wen;    id_is_load = v.ld;
        ex_fwd_wen = v.exw; ex_fwd_is_load = v.exl;
        ex_fwd_idx = v.exi; ex_fwd_data = v.exd;
        mem_fwd_wen = v.mw; mem_fwd_idx = v.mi; mem_fwd_data = v.md;
        id_pc = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[11];
    vec_t v;

    initial begin
        //        rs    rt    rd    rsv           rtv           imm        sh    s1    s2    op    wen  ld   exw  exl  exi   exd           mw   mi    md            e1            e2            ert
        vt[0]  = '{5'd5, 5'd6, 5'd1, 32'h1,        32'h66,       16'h0,     5'd0, 2'd0, 2'd0, 4'd0, 1'b1,1'b0,1'b1,1'b0,5'd5, 32'h22,       1'b1,5'd5, 32'h33,       32'h22,       32'h66,       32'h66};
        vt[1]  = '{5'd5, 5'd6, 5'd1, 32'h1,        32'h66,       16'h0,     5'd0, 2'd0, 2'd0, 4'd1, 1'b1,1'b0,1'b0,1'b0,5'd5, 32'h22,       1'b1,5'd5, 32'h33,       32'h33,       32'h66,       32'h66};
        vt[2]  = '{5'd0, 5'd0, 5'd2, 32'h55,       32'h77,       16'h0,     5'd0, 2'd0, 2'd0, 4'd2, 1'b1,1'b1,1'b1,1'b0,5'd0, 32'h22,       1'b1,5'd0, 32'h33,       32'h0,        32'h0,        32'h0};
        vt[3]  = '{5'd1, 5'd2, 5'd3, 32'h10,       32'h20,       16'h8001,  5'd3, 2'd1, 2'd1, 4'd3, 1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        32'h3,        32'hffff8001, 32'h20};
        vt[4]  = '{5'd1, 5'd2, 5'd4, 32'h10,       32'h20,       16'h8001,  5'd3, 2'd3, 2'd2, 4'd4, 1'b0,1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        32'h0,        32'h00008001, 32'h20};
        vt[5]  = '{5'd4, 5'd2, 5'd5, 32'hffffff22, 32'h20,       16'h8001,  5'd3, 2'd2, 2'd3, 4'd5, 1'b1,1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        32'h2,        32'h80010000, 32'h20};
        vt[6]  = '{5'd8, 5'd9, 5'd6, 32'h8,        32'h9,        16'h0,     5'd0, 2'd0, 2'd0, 4'd6, 1'b1,1'b0,1'b1,1'b0,5'd8, 32'he8,       1'b1,5'd9, 32'hd9,       32'he8,       32'hd9,       32'hd9};
        vt[7]  = '{5'd10,5'd10,5'd7, 32'ha,        32'hb,        16'h0,     5'd0, 2'd0, 2'd0, 4'd7, 1'b1,1'b0,1'b1,1'b0,5'd10,32'hea,       1'b1,5'd10,32'hda,       32'hea,       32'hea,       32'hea};
        vt[8]  = '{5'd11,5'd11,5'd8, 32'h1b,       32'h2b,       16'h0,     5'd0, 2'd0, 2'd0, 4'd8, 1'b1,1'b0,1'b0,1'b0,5'd11,32'heb,       1'b0,5'd11,32'hdb,       32'h1b,       32'h2b,       32'h2b};
        vt[9]  = '{5'd12,5'd3, 5'd9, 32'hc,        32'h3,        16'h7fff,  5'd0, 2'd0, 2'd1, 4'd9, 1'b1,1'b0,1'b1,1'b0,5'd12,32'hec,       1'b1,5'd3, 32'h99,       32'hec,       32'h00007fff, 32'h99};
        vt[10] = '{5'd13,5'd0, 5'd10,32'h0,        32'h5,        16'h0,     5'd0, 2'd2, 2'd0, 4'he, 1'b1,1'b0,1'b1,1'b0,5'd13,32'h12345677, 1'b0,5'd0, 32'h0,        32'h17,       32'h0,        32'h0};

        // Reset with ID already presenting an instruction.
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1; id_valid = 1'b1;
        apply(vt[0], 32'h100);
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
            chk("rst_src1", src1, 32'h0);
            chk("rst_src2", src2, 32'h0);
            chk("rst_id_ready", {31'b0, id_ready}, 32'h0);
        end
        rst = 1'b0;
        #1 chk("post_rst_id_ready", {31'b0, id_ready}, 32'h1);
        step();
        chk("first_cap_valid", {31'b0, ex_valid}, 32'h1);
        chk("first_cap_src1", src1, 32'h22);
        chk("first_cap_pc", ex_pc, 32'h100);

        // Back-to-back table vectors with ex_ready=1: one capture per cycle.
        for (int i = 0; i < 11; i++) begin
            apply(vt[i], 32'h1000 + 32'(i) * 4);
            #1 chk($sformatf("v%0d_id_ready", i), {31'b0, id_ready}, 32'h1);
            step();
            chk($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("v%0d_src1", i), src1, vt[i].e1);
            chk($sformatf("v%0d_src2", i), src2, vt[i].e2);
            chk($sformatf("v%0d_rt_fwd", i), ex_rt_fwd, vt[i].ert);
            chk($sformatf("v%0d_aluc", i), {28'b0, aluc}, {28'b0, vt[i].op});
            chk($sformatf("v%0d_pc", i), ex_pc, 32'h1000 + 32'(i) * 4);
            chk($sformatf("v%0d_rd", i), {27'b0, ex_rd_idx}, {27'b0, vt[i].rd});
            chk($sformatf("v%0d_wen", i), {31'b0, ex_wen}, {31'b0, vt[i].wen});
            chk($sformatf("v%0d_is_load", i), {31'b0, ex_is_load}, {31'b0, vt[i].ld});
        end

        // Load-use on rt: one bubble, then MEM supplies the loaded value.
        v = '{5'd1, 5'd7, 5'd2, 32'h0, 32'h1111, 16'h0, 5'd4, 2'd1, 2'd0, 4'd0, 1'b1, 1'b0,
              1'b1, 1'b1, 5'd7, 32'hdead, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        apply(v, 32'h1100);
        #1 chk("lu_id_ready", {31'b0, id_ready}, 32'h0);
        step();
        chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
        v.exw = 1'b0; v.exl = 1'b0; v.mw = 1'b1; v.mi = 5'd7; v.md = 32'habcd;
        apply(v, 32'h1100);
        #1 chk("lu_mem_id_ready", {31'b0, id_ready}, 32'h1);
        step();
        chk("lu_mem_valid", {31'b0, ex_valid}, 32'h1);
        chk("lu_mem_src2", src2, 32'habcd);
        chk("lu_mem_pc", ex_pc, 32'h1100);

        // Load target matches rs/rt but neither is used -> no stall.
        v = '{5'd7, 5'd7, 5'd2, 32'h0, 32'h0, 16'h1, 5'd4, 2'd1, 2'd1, 4'd0, 1'b1, 1'b0,
              1'b1, 1'b1, 5'd7, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        apply(v, 32'h1200);
        #1 chk("lu_unused_id_ready", {31'b0, id_ready}, 32'h1);
        v.wen = 1'b0;                       // store: rt is store data
        apply(v, 32'h1200);
        #1 chk("lu_store_id_ready", {31'b0, id_ready}, 32'h0);
        v.wen = 1'b1; v.s1 = 2'd2; v.rt = 5'd2;   // variable shift reads rs
        apply(v, 32'h1200);
        #1 chk("lu_vshift_id_ready", {31'b0, id_ready}, 32'h0);
        v.exi = 5'd0; v.rs = 5'd0;           // load to r0 never stalls
        apply(v, 32'h1200);
        #1 chk("lu_r0_id_ready", {31'b0, id_ready}, 32'h1);

        // Bubble: nothing offered, EX ready.
        id_valid = 1'b0;
        step();
        chk("idle_bubble", {31'b0, ex_valid}, 32'h0);

        // Hold: capture with ex_ready=0, then 3 stalled cycles.
        ex_ready = 1'b0; id_valid = 1'b1;
        v = '{5'd3, 5'd4, 5'd5, 32'h31, 32'h41, 16'h0, 5'd0, 2'd0, 2'd0, 4'd5, 1'b1, 1'b0,
              1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        apply(v, 32'h2000);
        step();
        chk("hold_cap_valid", {31'b0, ex_valid}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            v.rsv = 32'h500 + 32'(k); v.mw = 1'b1; v.mi = 5'd4; v.md = 32'h600 + 32'(k);
            apply(v, 32'h2100 + 32'(k));
            #1 chk($sformatf("hold%0d_id_ready", k), {31'b0, id_ready}, 32'h0);
            step();
            chk($sformatf("hold%0d_valid", k), {31'b0, ex_valid}, 32'h1);
            chk($sformatf("hold%0d_src1", k), src1, 32'h31);
            chk($sformatf("hold%0d_src2", k), src2, 32'h41);
            chk($sformatf("hold%0d_pc", k), ex_pc, 32'h2000);
            chk($sformatf("hold%0d_aluc", k), {28'b0, aluc}, 32'h5);
        end

        // Release with a new instruction on the same edge.
        ex_ready = 1'b1;
        v = '{5'd6, 5'd0, 5'd1, 32'h61, 32'h0, 16'h0, 5'd0, 2'd0, 2'd0, 4'd6, 1'b1, 1'b0,
              1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        apply(v, 32'h2004);
        #1 chk("handoff_id_ready", {31'b0, id_ready}, 32'h1);
        step();
        chk("handoff_valid", {31'b0, ex_valid}, 32'h1);
        chk("handoff_pc", ex_pc, 32'h2004);
        chk("handoff_src1", src1, 32'h61);

        // Flush while held, with ID offering a new instruction.
        ex_ready = 1'b0; flush = 1'b1;
        v.rsv = 32'h77;
        apply(v, 32'h3000);
        #1 chk("flush_id_ready", {31'b0, id_ready}, 32'h0);
        step();
        chk("flush_valid", {31'b0, ex_valid}, 32'h0);
        chk("flush_no_capture_pc", ex_pc, 32'h2004);
        flush = 1'b0;

        // Capture, hold a cycle, then reset mid-hold.
        v.rsv = 32'h88;
        apply(v, 32'h4000);
        step();
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'h1);
        chk("pre_rst_src1", src1, 32'h88);
        step();
        rst = 1'b1;
        step();
        chk("rst_hold_valid", {31'b0, ex_valid}, 32'h0);
        chk("rst_hold_src1", src1, 32'h0);
        chk("rst_hold_src2", src2, 32'h0);
        chk("rst_hold_pc", ex_pc, 32'h0);
        chk("rst_hold_aluc", {28'b0, aluc}, 32'h0);
        chk("rst_hold_rd", {27'b0, ex_rd_idx}, 32'h0);
        chk("rst_hold_wen", {31'b0, ex_wen}, 32'h0);
        chk("rst_hold_id_ready", {31'b0, id_ready}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
